// File: rtl/snake_dir_queue.sv
// Per-player snake direction controller: edge-detected key presses are queued
// per player, checked against the newest accepted direction, and applied one per game tick.
module snake_dir_queue #(
   parameter int unsigned PLAYERS = 2,
   parameter int unsigned QDEPTH  = 2,
   parameter int unsigned CW      = $clog2(QDEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tick,
   input  logic [PLAYERS*5-1:0]    btn,
   output logic [PLAYERS*5-1:0]    dir,
   output logic [PLAYERS*CW-1:0]   qlevel,
   output logic [PLAYERS-1:0]      restart
);

   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   localparam logic [4:0] D_UP      = 5'b00010;
   localparam logic [4:0] D_LEFT    = 5'b00100;
   localparam logic [4:0] D_DOWN    = 5'b01000;
   localparam logic [4:0] D_RIGHT   = 5'b10000;
   localparam logic [4:0] D_RESTART = 5'b11111;

   // START (00000) and RESTART have no opposite, so any direction follows them.
   function automatic logic is_opposite(input logic [4:0] a, input logic [4:0] b);
      case (a)
         D_UP:    return b == D_DOWN;
         D_DOWN:  return b == D_UP;
         D_LEFT:  return b == D_RIGHT;
         D_RIGHT: return b == D_LEFT;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(QDEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   genvar p;
   for (p = 0; p < PLAYERS; p++) begin : g_player
      logic [4:0]    btn_cur;
      logic [4:0]    btn_q, btn_d;
      logic [4:0]    dir_q, dir_d;
      logic [4:0]    fifo_q [QDEPTH];
      logic [4:0]    fifo_d [QDEPTH];
      logic [PW-1:0] rd_q, rd_d;
      logic [PW-1:0] wr_q, wr_d;
      logic [PW-1:0] last_ptr;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          rst_pulse_q, rst_pulse_d;
      logic          valid, press, press_restart, pop, push;
      logic [4:0]    tail;

      assign btn_cur = btn[5*p +: 5];

      // Press detection, tail reference, push/pop/flush decisions.
      always_comb begin
         btn_d       = btn_cur;
         dir_d       = dir_q;
         fifo_d      = fifo_q;
         rd_d        = rd_q;
         wr_d        = wr_q;
         cnt_d       = cnt_q;
         rst_pulse_d = 1'b0;

         valid = (btn_cur == D_UP) || (btn_cur == D_LEFT) || (btn_cur == D_DOWN) ||
                 (btn_cur == D_RIGHT) || (btn_cur == D_RESTART);
         press         = valid && (btn_cur != btn_q);
         press_restart = press && (btn_cur == D_RESTART);
         last_ptr      = (wr_q == '0) ? PW'(QDEPTH - 1) : wr_q - PW'(1);
         tail          = (cnt_q != '0) ? fifo_q[last_ptr] : dir_q;
         pop           = tick && (cnt_q != '0);
         push          = press && !press_restart && (dir_q != D_RESTART) &&
                         (btn_cur != tail) && !is_opposite(tail, btn_cur) &&
                         ((cnt_q != CW'(QDEPTH)) || pop);

         if (press_restart) begin
            rd_d        = '0;
            wr_d        = '0;
            cnt_d       = '0;
            dir_d       = D_RESTART;
            rst_pulse_d = 1'b1;
         end else begin
            if (pop) begin
               dir_d = fifo_q[rd_q];
               rd_d  = ptr_inc(rd_q);
            end else if (tick && (dir_q == D_RESTART)) begin
               dir_d = D_UP;
            end
            if (push) begin
               fifo_d[wr_q] = btn_cur;
               wr_d         = ptr_inc(wr_q);
            end
            case ({push, pop})
               2'b10:   cnt_d = cnt_q + CW'(1);
               2'b01:   cnt_d = cnt_q - CW'(1);
               default: cnt_d = cnt_q;
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            btn_q       <= '0;
            dir_q       <= '0;
            fifo_q      <= '{default: '0};
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            rst_pulse_q <= 1'b0;
         end else begin
            btn_q       <= btn_d;
            dir_q       <= dir_d;
            fifo_q      <= fifo_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            rst_pulse_q <= rst_pulse_d;
         end
      end

      assign dir[5*p +: 5]      = dir_q;
      assign qlevel[CW*p +: CW] = cnt_q;
      assign restart[p]         = rst_pulse_q;
   end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Scenario bench for snake_dir_queue (PLAYERS=2, QDEPTH=2): expected outputs are
// queued as each cycle is driven and compared once the clock edge has produced them.
module tb_snake_dir_queue;

   localparam logic [4:0] DS = 5'b00000;
   localparam logic [4:0] DU = 5'b00010;
   localparam logic [4:0] DL = 5'b00100;
   localparam logic [4:0] DD = 5'b01000;
   localparam logic [4:0] DR = 5'b10000;
   localparam logic [4:0] DX = 5'b11111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [9:0] btn;
   logic [9:0] dir;
   logic [3:0] qlevel;
   logic [1:0] restart;

   typedef struct {
      logic [9:0] b;
      logic       t;
      logic [9:0] d;
      logic [3:0] q;
      logic [1:0] r;
   } row_t;

   typedef struct {
      string       name;
      logic [15:0] v;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   snake_dir_queue #(.PLAYERS(2), .QDEPTH(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .btn     (btn),
      .dir     (dir),
      .qlevel  (qlevel),
      .restart (restart)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus on the falling edge, return just after the rising edge.
   task automatic step(input logic [9:0] b, input logic t);
      @(negedge clk);
      btn  = b;
      tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      row_t rows[$];
      exp_t e;
      rst_n = 1'b0;
      btn   = '0;
      tick  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back('{"reset_hold", 16'h0000});
      e = sb.pop_front();
      checks++;
      if ({dir, qlevel, restart} !== e.v) begin
         errors++;
         $display("FAIL %s: got %b want %b", e.name, {dir, qlevel, restart}, e.v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      rows.push_back('{{DS, DS}, 1'b1, {DS, DS}, 4'h0, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DS}, 4'h0, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DS}, 4'h0, 2'b00});
      rows.push_back('{{DS, DR}, 1'b0, {DS, DS}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DR}, 4'h0, 2'b00});
      foreach (rows[i]) begin
         sb.push_back('{$sformatf("start[%0d]", i), {rows[i].d, rows[i].q, rows[i].r}});
         step(rows[i].b, rows[i].t);
         e = sb.pop_front();
         checks++;
         if ({dir, qlevel, restart} !== e.v) begin
            errors++;
            $display("FAIL %s: got dir=%b qlevel=%b restart=%b want %b", e.name, dir, qlevel, restart, e.v);
         end
      end
   endtask

   task automatic test_reversal();
      row_t rows[$];
      exp_t e;
      rows.push_back('{{DS, DU}, 1'b0, {DS, DR}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DU}, 4'h0, 2'b00});
      rows.push_back('{{DS, DD}, 1'b0, {DS, DU}, 4'h0, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DU}, 4'h0, 2'b00});
      foreach (rows[i]) begin
         sb.push_back('{$sformatf("reversal[%0d]", i), {rows[i].d, rows[i].q, rows[i].r}});
         step(rows[i].b, rows[i].t);
         e = sb.pop_front();
         checks++;
         if ({dir, qlevel, restart} !== e.v) begin
            errors++;
            $display("FAIL %s: got dir=%b qlevel=%b restart=%b want %b", e.name, dir, qlevel, restart, e.v);
         end
      end
   endtask

   task automatic test_buffered();
      row_t rows[$];
      exp_t e;
      rows.push_back('{{DS, DR}, 1'b0, {DS, DU}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DR}, 4'h0, 2'b00});
      rows.push_back('{{DS, DU}, 1'b0, {DS, DR}, 4'h1, 2'b00});
      rows.push_back('{{DS, DL}, 1'b0, {DS, DR}, 4'h2, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DU}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DL}, 4'h0, 2'b00});
      foreach (rows[i]) begin
         sb.push_back('{$sformatf("buffered[%0d]", i), {rows[i].d, rows[i].q, rows[i].r}});
         step(rows[i].b, rows[i].t);
         e = sb.pop_front();
         checks++;
         if ({dir, qlevel, restart} !== e.v) begin
            errors++;
            $display("FAIL %s: got dir=%b qlevel=%b restart=%b want %b", e.name, dir, qlevel, restart, e.v);
         end
      end
   endtask

   task automatic test_full_push_pop();
      row_t rows[$];
      exp_t e;
      rows.push_back('{{DS, DU}, 1'b0, {DS, DL}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DU}, 4'h0, 2'b00});
      rows.push_back('{{DS, DR}, 1'b0, {DS, DU}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DR}, 4'h0, 2'b00});
      rows.push_back('{{DS, DU}, 1'b0, {DS, DR}, 4'h1, 2'b00});
      rows.push_back('{{DS, DL}, 1'b0, {DS, DR}, 4'h2, 2'b00});
      rows.push_back('{{DS, DD}, 1'b0, {DS, DR}, 4'h2, 2'b00});
      rows.push_back('{{DS, DS}, 1'b0, {DS, DR}, 4'h2, 2'b00});
      rows.push_back('{{DS, DD}, 1'b1, {DS, DU}, 4'h2, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DL}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DD}, 4'h0, 2'b00});
      foreach (rows[i]) begin
         sb.push_back('{$sformatf("full_push_pop[%0d]", i), {rows[i].d, rows[i].q, rows[i].r}});
         step(rows[i].b, rows[i].t);
         e = sb.pop_front();
         checks++;
         if ({dir, qlevel, restart} !== e.v) begin
            errors++;
            $display("FAIL %s: got dir=%b qlevel=%b restart=%b want %b", e.name, dir, qlevel, restart, e.v);
         end
      end
   endtask

   task automatic test_no_bypass();
      row_t rows[$];
      exp_t e;
      rows.push_back('{{DS, DL}, 1'b1, {DS, DD}, 4'h1, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DS, DL}, 4'h0, 2'b00});
      rows.push_back('{{DS, DL}, 1'b0, {DS, DL}, 4'h0, 2'b00});
      foreach (rows[i]) begin
         sb.push_back('{$sformatf("no_bypass[%0d]", i), {rows[i].d, rows[i].q, rows[i].r}});
         step(rows[i].b, rows[i].t);
         e = sb.pop_front();
         checks++;
         if ({dir, qlevel, restart} !== e.v) begin
            errors++;
            $display("FAIL %s: got dir=%b qlevel=%b restart=%b want %b", e.name, dir, qlevel, restart, e.v);
         end
      end
   endtask

   task automatic test_restart();
      row_t rows[$];
      exp_t e;
      rows.push_back('{{DR, DU}, 1'b0, {DS, DL}, 4'b0101, 2'b00});
      rows.push_back('{{DU, DU}, 1'b0, {DS, DL}, 4'b1001, 2'b00});
      rows.push_back('{{DX, DS}, 1'b1, {DX, DU}, 4'b0000, 2'b10});
      rows.push_back('{{DL, DS}, 1'b0, {DX, DU}, 4'b0000, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DU, DU}, 4'b0000, 2'b00});
      rows.push_back('{{DL, DS}, 1'b0, {DU, DU}, 4'b0100, 2'b00});
      rows.push_back('{{DS, DS}, 1'b1, {DL, DU}, 4'b0000, 2'b00});
      foreach (rows[i]) begin
         sb.push_back('{$sformatf("restart[%0d]", i), {rows[i].d, rows[i].q, rows[i].r}});
         step(rows[i].b, rows[i].t);
         e = sb.pop_front();
         checks++;
         if ({dir, qlevel, restart} !== e.v) begin
            errors++;
            $display("FAIL %s: got dir=%b qlevel=%b restart=%b want %b", e.name, dir, qlevel, restart, e.v);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      sb.push_back('{"async_fill", {{DL, DU}, 4'b0101, 2'b00}});
      step({DD, DR}, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({dir, qlevel, restart} !== e.v) begin
         errors++;
         $display("FAIL %s: got %b want %b", e.name, {dir, qlevel, restart}, e.v);
      end
      @(negedge clk);
      btn  = '0;
      tick = 1'b0;
      #2;
      rst_n = 1'b0;
      sb.push_back('{"async_assert", 16'h0000});
      #1;
      e = sb.pop_front();
      checks++;
      if ({dir, qlevel, restart} !== e.v) begin
         errors++;
         $display("FAIL %s: got %b want %b", e.name, {dir, qlevel, restart}, e.v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{"async_release_tick", 16'h0000});
      step({DS, DS}, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({dir, qlevel, restart} !== e.v) begin
         errors++;
         $display("FAIL %s: got %b want %b", e.name, {dir, qlevel, restart}, e.v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_reversal();
      test_buffered();
      test_full_push_pop();
      test_no_bypass();
      test_restart();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
